// File: rtl/stream_wrr_arbiter.sv
// rtl/stream_wrr_arbiter.sv - packet-locking source arbiter (round-robin, weighted RR, fixed priority)
module stream_wrr_arbiter #(
   parameter int S_DATA_COUNT = 5,
   parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
   parameter int WEIGHT_WIDTH = 4,
   parameter int ARB_MODE     = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [S_DATA_COUNT-1:0]          s_valid_i,
   input  logic [S_DATA_COUNT-1:0]          s_last_i,
   input  logic [S_DATA_COUNT*WEIGHT_WIDTH-1:0] weight_i,
   input  logic                             m_ready_i,
   output logic [S_DATA_COUNT-1:0]          grant_o,
   output logic [T_ID___WIDTH-1:0]          m_id_o,
   output logic                             m_valid_o,
   output logic                             m_last_o,
   output logic                             busy_o
);

   localparam int IW = T_ID___WIDTH + 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                    state, state_n;
   logic [T_ID___WIDTH-1:0]   ptr, ptr_n;
   logic [WEIGHT_WIDTH-1:0]   credit, credit_n;
   logic [S_DATA_COUNT-1:0]   grant_n;
   logic [T_ID___WIDTH-1:0]   id_n;

   logic                      found;
   logic [T_ID___WIDTH-1:0]   win;
   logic [IW-1:0]             start;
   logic [IW-1:0]             idx;
   logic [WEIGHT_WIDTH-1:0]   win_weight;
   logic [IW-1:0]             inc;
   logic [T_ID___WIDTH-1:0]   next_id;
   logic                      last_xfer;

   assign busy_o    = (state == LOCKED);
   assign m_valid_o = busy_o & s_valid_i[m_id_o];
   assign m_last_o  = m_valid_o & s_last_i[m_id_o];
   assign last_xfer = m_valid_o & m_ready_i & m_last_o;

   // Circular search from the pointer; fixed priority always starts at source 0.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      start = (ARB_MODE == 2) ? '0 : {1'b0, ptr};
      for (int i = 0; i < S_DATA_COUNT; i++) begin
         idx = start + IW'(i);
         if (idx >= IW'(S_DATA_COUNT))
            idx = idx - IW'(S_DATA_COUNT);
         if (!found && s_valid_i[idx[T_ID___WIDTH-1:0]]) begin
            found = 1'b1;
            win   = idx[T_ID___WIDTH-1:0];
         end
      end
   end

   always_comb begin
      win_weight = '0;
      for (int k = 0; k < S_DATA_COUNT; k++) begin
         if (win == T_ID___WIDTH'(k))
            win_weight = weight_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
   end

   always_comb begin
      inc     = {1'b0, m_id_o} + IW'(1);
      next_id = (inc == IW'(S_DATA_COUNT)) ? '0 : inc[T_ID___WIDTH-1:0];
   end

   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      credit_n = credit;
      grant_n  = grant_o;
      id_n     = m_id_o;
      case (state)
         IDLE: begin
            if (found) begin
               state_n      = LOCKED;
               grant_n      = '0;
               grant_n[win] = 1'b1;
               id_n         = win;
               // A new owner, or an exhausted turn, starts a fresh credit count.
               if (ARB_MODE == 1 && (win != ptr || credit == '0))
                  credit_n = (win_weight == '0) ? WEIGHT_WIDTH'(1) : win_weight;
            end
         end
         LOCKED: begin
            if (last_xfer) begin
               state_n = IDLE;
               grant_n = '0;
               case (ARB_MODE)
                  0: ptr_n = next_id;
                  1: begin
                     if (credit <= WEIGHT_WIDTH'(1)) begin
                        ptr_n    = next_id;
                        credit_n = '0;
                     end else begin
                        ptr_n    = m_id_o;
                        credit_n = credit - WEIGHT_WIDTH'(1);
                     end
                  end
                  default: ptr_n = '0;
               endcase
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         credit  <= '0;
         grant_o <= '0;
         m_id_o  <= '0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         credit  <= credit_n;
         grant_o <= grant_n;
         m_id_o  <= id_n;
      end
   end

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// tb/tb_stream_wrr_arbiter.sv - scoreboard bench for stream_wrr_arbiter in all three modes
module tb_stream_wrr_arbiter;

   localparam int N  = 5;
   localparam int TW = 3;
   localparam int WW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    s_valid = '0;
   logic [N-1:0]    s_last = '0;
   logic [N*WW-1:0] weight = {N{4'd1}};
   logic            m_ready = 1'b0;

   logic [N-1:0]    grant_w [3];
   logic [TW-1:0]   id_w    [3];
   logic            mv_w    [3];
   logic            ml_w    [3];
   logic            busy_w  [3];

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   stream_wrr_arbiter #(.S_DATA_COUNT(N), .T_ID___WIDTH(TW), .WEIGHT_WIDTH(WW), .ARB_MODE(0)) u_rr (
      .clk(clk), .rst(rst), .s_valid_i(s_valid), .s_last_i(s_last), .weight_i(weight),
      .m_ready_i(m_ready), .grant_o(grant_w[0]), .m_id_o(id_w[0]), .m_valid_o(mv_w[0]),
      .m_last_o(ml_w[0]), .busy_o(busy_w[0]));

   stream_wrr_arbiter #(.S_DATA_COUNT(N), .T_ID___WIDTH(TW), .WEIGHT_WIDTH(WW), .ARB_MODE(1)) u_wrr (
      .clk(clk), .rst(rst), .s_valid_i(s_valid), .s_last_i(s_last), .weight_i(weight),
      .m_ready_i(m_ready), .grant_o(grant_w[1]), .m_id_o(id_w[1]), .m_valid_o(mv_w[1]),
      .m_last_o(ml_w[1]), .busy_o(busy_w[1]));

   stream_wrr_arbiter #(.S_DATA_COUNT(N), .T_ID___WIDTH(TW), .WEIGHT_WIDTH(WW), .ARB_MODE(2)) u_fp (
      .clk(clk), .rst(rst), .s_valid_i(s_valid), .s_last_i(s_last), .weight_i(weight),
      .m_ready_i(m_ready), .grant_o(grant_w[2]), .m_id_o(id_w[2]), .m_valid_o(mv_w[2]),
      .m_last_o(ml_w[2]), .busy_o(busy_w[2]));

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      s_valid = '0;
      s_last  = '0;
      m_ready = 1'b0;
      weight  = {N{4'd1}};
      step();
      step();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Continuous single-beat traffic: grants alternate with bubbles and follow the queued order.
   task automatic run_queue(input int m, input int budget);
      int           c = 0;
      int           e;
      logic [N-1:0] prev = '0;
      logic [N-1:0] one = 1;
      while ((exp_q.size() > 0 || grant_w[m] != '0) && c < budget) begin
         step();
         c++;
         total++;
         if ((grant_w[m] != '0) !== (c % 2 == 1)) begin
            bad++;
            $display("FAIL grant_timing dut%0d cycle %0d: grant=%b, nonzero grant required=%0d", m, c, grant_w[m], (c % 2 == 1));
         end
         if (grant_w[m] != '0 && prev == '0) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_grant dut%0d: got id=%0d, none required", m, id_w[m]);
            end else begin
               e = exp_q.pop_front();
               if (id_w[m] !== TW'(e) || grant_w[m] !== (one << e)) begin
                  bad++;
                  $display("FAIL grant_order dut%0d: got id=%0d grant=%b, required id=%0d", m, id_w[m], grant_w[m], e);
               end
            end
         end
         prev = grant_w[m];
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL queue_drained dut%0d: %0d grants outstanding, required 0", m, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int m = 0; m < 3; m++) begin
         total++;
         if ({grant_w[m], id_w[m], busy_w[m], mv_w[m], ml_w[m]} !== 11'd0) begin
            bad++;
            $display("FAIL reset_state dut%0d: got %b, required 0", m, {grant_w[m], id_w[m], busy_w[m], mv_w[m], ml_w[m]});
         end
      end
      // Move the pointers past source 3 first.
      s_valid = 5'b01000; s_last = 5'b01000; m_ready = 1'b1;
      step();
      total++;
      if (id_w[0] !== 3'd3) begin
         bad++;
         $display("FAIL rst_pre_grant: got id=%0d, required 3", id_w[0]);
      end
      step();
      s_valid = 5'b00100; s_last = 5'b00000;
      step();
      total++;
      if (grant_w[0] !== 5'b00100 || busy_w[0] !== 1'b1) begin
         bad++;
         $display("FAIL rst_lock_src2: got grant=%b busy=%b, required 00100 1", grant_w[0], busy_w[0]);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int m = 0; m < 3; m++) begin
         total++;
         if (grant_w[m] !== 5'b0 || id_w[m] !== 3'd0 || busy_w[m] !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_packet dut%0d: got grant=%b id=%0d busy=%b, required 0 0 0", m, grant_w[m], id_w[m], busy_w[m]);
         end
      end
      s_valid = 5'b10010; s_last = 5'b10010;
      step();
      for (int m = 0; m < 2; m++) begin
         total++;
         if (id_w[m] !== 3'd1 || grant_w[m] !== 5'b00010) begin
            bad++;
            $display("FAIL rst_ptr_cleared dut%0d: got id=%0d grant=%b, required 1 00010", m, id_w[m], grant_w[m]);
         end
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      s_valid = 5'b11111; s_last = 5'b11111; m_ready = 1'b1;
      exp_q = '{0, 1, 2, 3, 4, 0};
      run_queue(0, 40);
   endtask

   task automatic test_weighted();
      do_reset();
      weight  = {4'd1, 4'd3, 4'd1, 4'd1, 4'd1};
      s_valid = 5'b01010; s_last = 5'b11111; m_ready = 1'b1;
      exp_q = '{1, 3, 3, 3, 1, 3, 3, 3};
      run_queue(1, 60);
   endtask

   task automatic test_forfeit();
      do_reset();
      weight  = {4'd1, 4'd1, 4'd1, 4'd1, 4'd3};
      s_valid = 5'b00001; s_last = 5'b11111; m_ready = 1'b1;
      exp_q = '{0};
      run_queue(1, 10);
      s_valid = 5'b10000;
      exp_q = '{4};
      run_queue(1, 10);
      s_valid = 5'b00011;
      exp_q = '{0, 0, 0, 1};
      run_queue(1, 40);
   endtask

   task automatic test_backpressure();
      logic v1  [9] = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
      logic rdy [9] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
      int   beats = 0;
      int   e;
      do_reset();
      s_valid = 5'b01010; s_last = 5'b00000; m_ready = 1'b1;
      step();
      exp_q = '{0, 0, 0, 1};
      for (int k = 0; k < 9; k++) begin
         s_valid = {1'b0, 1'b1, 1'b0, v1[k], 1'b0};
         s_last  = (beats == 3) ? 5'b00010 : 5'b00000;
         m_ready = rdy[k];
         #1;
         total++;
         if (grant_w[0] !== 5'b00010 || busy_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold k=%0d: got grant=%b busy=%b, required 00010 1", k, grant_w[0], busy_w[0]);
         end
         total++;
         if (mv_w[0] !== v1[k]) begin
            bad++;
            $display("FAIL bp_valid_follow k=%0d: got %b, required %b", k, mv_w[0], v1[k]);
         end
         if (mv_w[0] && m_ready) begin
            beats++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL bp_extra_beat k=%0d: got beat %0d, required at most 4", k, beats);
            end else begin
               e = exp_q.pop_front();
               if (ml_w[0] !== e[0]) begin
                  bad++;
                  $display("FAIL bp_last k=%0d: got %b, required %0d", k, ml_w[0], e);
               end
            end
         end
         step();
      end
      total++;
      if (grant_w[0] !== 5'b0 || busy_w[0] !== 1'b0) begin
         bad++;
         $display("FAIL bp_release: got grant=%b busy=%b, required 0 0", grant_w[0], busy_w[0]);
      end
      total++;
      if (beats != 4 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL bp_beats: got %0d transfers, required 4", beats);
      end
      s_last = 5'b00000;
      step();
      total++;
      if (id_w[0] !== 3'd3 || grant_w[0] !== 5'b01000) begin
         bad++;
         $display("FAIL bp_next: got id=%0d grant=%b, required 3 01000", id_w[0], grant_w[0]);
      end
      exp_q.delete();
   endtask

   task automatic test_priority();
      do_reset();
      s_valid = 5'b10010; s_last = 5'b11111; m_ready = 1'b1;
      exp_q = '{1, 1, 1};
      run_queue(2, 20);
      s_valid = 5'b10000;
      exp_q = '{4};
      run_queue(2, 10);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_weighted();
      test_forfeit();
      test_backpressure();
      test_priority();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
